inhibit_register: RTL

INHIBIT_REGISTER -- requirements
Module: inhibit_register

---
 rtl/inhibit_register.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/inhibit_register.sv
// Serial-to-parallel inhibit register: assembles an odd-parity word from serial bits,
// then drives the per-bit inhibit lines for a fixed window when the write phase starts.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_COLLECT | shifting serial bits into the word, LSB first
// S_FULL    | word complete with parity, waiting for wr_go
// S_DRIVE   | inhibit drivers enabled for INH_CYCLES clocks
module inhibit_register #(
    parameter int NBITS      = 13,
    parameter int INH_CYCLES = 4
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_bit_strobe,
    input  logic             i_sdata,
    input  logic             i_syl_start,
    input  logic             i_wr_go,
    input  logic             i_clr_err,
    output logic [NBITS:0]   o_word,
    output logic             o_full,
    output logic             o_inh_en,
    output logic [NBITS:0]   o_inh,
    output logic             o_done,
    output logic             o_ovr,
    output logic             o_unr
);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_FULL    = 2'd1,
        S_DRIVE   = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NBITS - 1);
    localparam logic [3:0] DRV_LOAD = 4'(INH_CYCLES - 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [3:0]     r_cnt;
    logic [3:0]     w_cnt_nxt;
    logic [3:0]     r_drv_cnt;
    logic [3:0]     w_drv_cnt_nxt;
    logic [NBITS:0] r_word;
    logic [NBITS:0] w_word_nxt;
    logic           r_done;
    logic           w_done_nxt;
    logic           r_ovr;
    logic           r_unr;
    logic [3:0]     w_idx;
    logic           w_last;
    logic           w_drv_tc;

    // A syllable start coinciding with a strobe makes that strobe bit 0.
    assign w_idx    = i_syl_start ? 4'd0 : r_cnt;
    assign w_last   = i_bit_strobe && (w_idx == LAST_IDX);
    assign w_drv_tc = (r_drv_cnt == 4'd0);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_COLLECT: if (w_last)   w_state_nxt = S_FULL;
            S_FULL:    if (i_wr_go)  w_state_nxt = S_DRIVE;
            S_DRIVE:   if (w_drv_tc) w_state_nxt = S_COLLECT;
            default:                 w_state_nxt = S_COLLECT;
        endcase
    end

    always_comb begin
        o_full   = (r_state == S_FULL);
        o_inh_en = (r_state == S_DRIVE);
        o_inh    = (r_state == S_DRIVE) ? ~r_word : '0;
        o_word   = r_word;
        o_done   = r_done;
        o_ovr    = r_ovr;
        o_unr    = r_unr;
    end

    always_comb begin
        w_word_nxt    = r_word;
        w_cnt_nxt     = r_cnt;
        w_drv_cnt_nxt = r_drv_cnt;
        w_done_nxt    = 1'b0;
        case (r_state)
            S_COLLECT: begin
                if (i_syl_start) begin
                    w_word_nxt = '0;
                    w_cnt_nxt  = 4'd0;
                end
                if (i_bit_strobe) begin
                    w_word_nxt[w_idx] = i_sdata;
                    if (w_last) begin
                        w_word_nxt[NBITS] = ~(^w_word_nxt[NBITS-1:0]);
                        w_cnt_nxt         = 4'd0;
                    end else begin
                        w_cnt_nxt = 4'(w_idx + 4'd1);
                    end
                end
            end
            S_FULL: begin
                if (i_wr_go) w_drv_cnt_nxt = DRV_LOAD;
            end
            S_DRIVE: begin
                if (w_drv_tc) begin
                    w_done_nxt = 1'b1;
                    w_word_nxt = '0;
                end else begin
                    w_drv_cnt_nxt = 4'(r_drv_cnt - 4'd1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_word    <= '0;
            r_cnt     <= 4'd0;
            r_drv_cnt <= 4'd0;
            r_done    <= 1'b0;
            r_ovr     <= 1'b0;
            r_unr     <= 1'b0;
        end else begin
            r_word    <= w_word_nxt;
            r_cnt     <= w_cnt_nxt;
            r_drv_cnt <= w_drv_cnt_nxt;
            r_done    <= w_done_nxt;
            // A new error event wins over a simultaneous clear.
            r_ovr     <= (r_ovr & ~i_clr_err) | (i_bit_strobe & (r_state != S_COLLECT));
            r_unr     <= (r_unr & ~i_clr_err) | (i_wr_go & (r_state != S_FULL));
        end
    end

endmodule
